// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Definitions shared by the waveform generators and the I2S transmitter:
//   AUDIO_SAMPLE_W : width of one audio sample (two's complement)
//   I2S_SLOT_W     : BCLK periods per I2S channel slot
//   sample_t       : signed audio sample type
// ---------------------------------------------------------------------------
package audio_pkg;

   localparam int AUDIO_SAMPLE_W = 16;
   localparam int I2S_SLOT_W     = 32;

   typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_clk_div.sv
// ---------------------------------------------------------------------------
// i2s_clk_div
// Divides the system clock down to the I2S bit clock and reports the clk
// cycle in which each BCLK edge is registered.
//   clk       in  system clock
//   rst       in  asynchronous, active-high reset
//   bclk      out bit clock, toggles every CLK_DIV clk cycles
//   bclk_rise out high in the clk cycle whose edge drives bclk 0->1
//   bclk_fall out high in the clk cycle whose edge drives bclk 1->0
// ---------------------------------------------------------------------------
module i2s_clk_div
   import audio_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   output logic bclk,
   output logic bclk_rise,
   output logic bclk_fall
);

   localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             div_tc;

   assign div_tc    = (div_cnt == CNT_LAST);
   // Strobes lead the registered bclk edge by one cycle so that consumers
   // can update their own registers on the same clk edge as bclk toggles.
   assign bclk_rise = div_tc & ~bclk;
   assign bclk_fall = div_tc &  bclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (div_tc) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
// Serializes mono signed samples onto an I2S link; each accepted sample is
// sent in both the left and right slot of one frame. If no new sample is
// waiting at a frame boundary the previous word is repeated.
//   clk          in  system clock
//   rst          in  asynchronous, active-high reset
//   sample_in    in  signed sample from the waveform generator
//   sample_valid in  sample_in is valid
//   sample_ready out holding buffer empty; accept on valid && ready
//   bclk         out I2S bit clock
//   lrck         out I2S word select (0 = left, 1 = right)
//   sdata        out I2S serial data, MSB first, one BCLK after LRCK edge
//   frame_start  out one-clk pulse when a new frame word is loaded
//   underrun     out one-clk pulse with frame_start when the word was reused
// ---------------------------------------------------------------------------
module i2s_tx_serializer
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = AUDIO_SAMPLE_W,
   parameter int SLOT_W   = I2S_SLOT_W,
   parameter int CLK_DIV  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   output logic                       bclk,
   output logic                       lrck,
   output logic                       sdata,
   output logic                       frame_start,
   output logic                       underrun
);

   localparam int            FB_W    = $clog2(2 * SLOT_W);
   localparam logic [FB_W-1:0] FB_LAST = FB_W'(2 * SLOT_W - 1);
   localparam logic [FB_W-1:0] SLOT_V  = FB_W'(SLOT_W);

   logic                       bclk_rise;
   logic                       bclk_fall;
   logic                       hold_full;
   logic signed [SAMPLE_W-1:0] hold_reg;
   logic signed [SAMPLE_W-1:0] frame_word;
   logic [FB_W-1:0]            fb;
   logic [FB_W-1:0]            fb_next;
   logic                       accept;
   logic                       load;

   // Bit of the frame word driven at frame position f: the slot position
   // p = f mod SLOT_W carries bit SAMPLE_W-p for 1 <= p <= SAMPLE_W, which
   // yields the I2S one-bit delay and zero padding to the end of the slot.
   function automatic logic slot_bit(input logic signed [SAMPLE_W-1:0] w,
                                     input logic [FB_W-1:0]            f);
      logic [FB_W-1:0] p;
      logic            b;
      p = (f >= SLOT_V) ? f - SLOT_V : f;
      b = 1'b0;
      for (int i = 0; i < SAMPLE_W; i++) begin
         if (p == FB_W'(SAMPLE_W - i)) b = w[i];
      end
      return b;
   endfunction

   i2s_clk_div #(
      .CLK_DIV   (CLK_DIV)
   ) u_clk_div (
      .clk       (clk),
      .rst       (rst),
      .bclk      (bclk),
      .bclk_rise (bclk_rise),
      .bclk_fall (bclk_fall)
   );

   // Outputs only move on BCLK falls; the divider never flags both edges.
   assert property (@(posedge clk) disable iff (rst) !(bclk_rise && bclk_fall));

   assign sample_ready = ~hold_full;
   assign accept       = sample_valid & ~hold_full;
   assign fb_next      = (fb == FB_LAST) ? '0 : fb + 1'b1;
   assign load         = bclk_fall & (fb == FB_LAST);

   // Holding buffer. A load empties it, but an accept in the same cycle
   // (possible only when it was already empty) refills it for next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_full <= 1'b0;
         hold_reg  <= '0;
      end else begin
         if (accept) begin
            hold_reg  <= sample_in;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

   // Frame counter, frame word and registered I2S outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb          <= FB_LAST;
         frame_word  <= '0;
         lrck        <= 1'b0;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= load;
         underrun    <= load & ~hold_full;
         if (load && hold_full) frame_word <= hold_reg;
         if (bclk_fall) begin
            fb    <= fb_next;
            lrck  <= (fb_next >= SLOT_V);
            // Position 0 is always padding, so the stale frame_word seen
            // during the load cycle never reaches the wire.
            sdata <= slot_bit(frame_word, fb_next);
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_serializer
// Scoreboard bench: the stimulus side keeps a frame-level model (holding
// buffer, last word, frame load instants derived from the clock ratio) and
// queues the expected word and underrun flag of every frame. A monitor
// decodes the serial stream on rising BCLK and compares whole frames.
// ---------------------------------------------------------------------------
module tb_i2s_tx_serializer;
   import audio_pkg::*;

   localparam int CLK_DIV    = 2;
   localparam int SLOT_W     = 32;
   localparam int SAMPLE_W   = 16;
   localparam int FRAME_CLKS = 2 * CLK_DIV * 2 * SLOT_W;
   localparam int FIRST_LOAD = 2 * CLK_DIV;

   typedef struct packed {
      logic [SAMPLE_W-1:0] w;
      logic                ur;
   } exp_t;

   logic    clk = 1'b0;
   logic    rst = 1'b0;
   sample_t sample_in = '0;
   logic    sample_valid = 1'b0;
   logic    sample_ready;
   logic    bclk;
   logic    lrck;
   logic    sdata;
   logic    frame_start;
   logic    underrun;

   i2s_tx_serializer #(
      .SAMPLE_W     (SAMPLE_W),
      .SLOT_W       (SLOT_W),
      .CLK_DIV      (CLK_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .bclk         (bclk),
      .lrck         (lrck),
      .sdata        (sdata),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   // Reference model state
   int                  n;          // clk edges since reset release
   logic                m_full;
   logic [SAMPLE_W-1:0] m_hold;
   logic [SAMPLE_W-1:0] m_last;
   logic                last_acc;
   exp_t                expq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_load(input int c);
      return (c >= FIRST_LOAD) && (((c - FIRST_LOAD) % FRAME_CLKS) == 0);
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_bclk"},  32'(bclk),         32'd0);
      chk({tag, "_lrck"},  32'(lrck),         32'd0);
      chk({tag, "_sdata"}, 32'(sdata),        32'd0);
      chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
      chk({tag, "_fs"},    32'(frame_start),  32'd0);
      chk({tag, "_ur"},    32'(underrun),     32'd0);
   endtask

   // Called at a negedge; raises rst between clock edges.
   task automatic do_reset();
      rst = 1'b1;
      sample_valid = 1'b0;
      sample_in = '0;
      n = 0; m_full = 1'b0; m_hold = '0; m_last = '0; last_acc = 1'b0;
      expq.delete();
      #1 check_reset("rst_async");
      repeat (5) @(negedge clk);
      check_reset("rst_held");
      rst = 1'b0;
   endtask

   // One clk cycle of stimulus plus the model update for that edge.
   task automatic tick(input logic v, input logic [SAMPLE_W-1:0] d);
      logic ld;
      exp_t e;
      sample_valid = v;
      sample_in = d;
      @(posedge clk);
      n++;
      ld = is_load(n);
      last_acc = v && !m_full;
      if (ld) begin
         if (m_full) m_last = m_hold;
         e.w = m_last;
         e.ur = !m_full;
         expq.push_back(e);
         m_full = 1'b0;
      end
      if (last_acc) begin
         m_hold = d;
         m_full = 1'b1;
      end
      @(negedge clk);
      chk("bclk",        32'(bclk),         32'((n / CLK_DIV) % 2));
      chk("frame_start", 32'(frame_start),  32'(ld));
      chk("underrun_t",  32'(underrun),     32'(ld && e.ur));
      chk("ready",       32'(sample_ready), 32'(!m_full));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) tick(1'b0, SAMPLE_W'($urandom));
   endtask

   // Present a sample and hold it until the handshake completes.
   task automatic send(input logic [SAMPLE_W-1:0] d);
      int k;
      k = 0;
      do begin
         tick(1'b1, d);
         k++;
      end while (!last_acc && k < 2000);
      if (!last_acc) begin
         nvec++; nmis++;
         $display("FAIL send_timeout: got no accept expected accept of %h", d);
      end
      sample_valid = 1'b0;
   endtask

   // Monitor: decode each frame on rising BCLK and compare on the next load.
   logic           prev_bclk = 1'b0;
   bit             in_frame = 1'b0;
   int             nbits = 0;
   logic [63:0]    bits;
   logic [63:0]    lrs;
   exp_t           cur;

   task automatic finish_frame();
      logic [SAMPLE_W-1:0] left, right;
      logic                pad;
      int                  lr_bad;
      int                  p;
      left = '0; right = '0; pad = 1'b0; lr_bad = 0;
      chk("bits_per_frame", 32'(nbits), 32'd64);
      for (int k = 0; k < 64; k++) begin
         p = k % SLOT_W;
         if (p >= 1 && p <= SAMPLE_W) begin
            if (k < SLOT_W) left  = {left[SAMPLE_W-2:0],  bits[k]};
            else            right = {right[SAMPLE_W-2:0], bits[k]};
         end else begin
            pad = pad | bits[k];
         end
         if (lrs[k] !== (k >= SLOT_W)) lr_bad++;
      end
      chk("left_word",   32'(left),   32'(cur.w));
      chk("right_word",  32'(right),  32'(cur.w));
      chk("zero_pad",    32'(pad),    32'd0);
      chk("lrck_layout", 32'(lr_bad), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         nbits = 0;
         prev_bclk = 1'b0;
      end else begin
         if (frame_start) begin
            if (in_frame) finish_frame();
            if (expq.size() == 0) begin
               nvec++; nmis++;
               $display("FAIL frame_queue: got frame_start expected none queued (t=%0t)", $time);
               in_frame = 1'b0;
            end else begin
               cur = expq.pop_front();
               chk("underrun_frame", 32'(underrun), 32'(cur.ur));
               in_frame = 1'b1;
               nbits = 0;
            end
         end
         if (bclk && !prev_bclk && in_frame && nbits < 64) begin
            bits[nbits] = sdata;
            lrs[nbits]  = lrck;
            nbits++;
         end
         prev_bclk = bclk;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      @(negedge clk);

      // Idle after reset: frames of zero, each flagged as underrun.
      do_reset();
      idle(2 * FRAME_CLKS + 20);

      // Sample offered before the first frame load.
      do_reset();
      send(16'hA5C3);
      idle(2 * FRAME_CLKS);

      // Back-to-back stream, offered as soon as ready.
      send(16'h8000);
      send(16'h7FFF);
      send(16'h0001);
      for (int i = 0; i < 6; i++) send(SAMPLE_W'($urandom));
      idle(2 * FRAME_CLKS);

      // Starvation then recovery.
      send(16'h1234);
      idle(3 * FRAME_CLKS);
      send(16'h4321);
      idle(2 * FRAME_CLKS);

      // Offer a sample exactly in the clk of a load with an empty buffer.
      k = 0;
      while (!(is_load(n + 1) && !m_full) && k < 2000) begin
         tick(1'b0, '0);
         k++;
      end
      chk("load_align", 32'(k < 2000), 32'd1);
      tick(1'b1, 16'h5A5A);
      sample_valid = 1'b0;
      idle(2 * FRAME_CLKS + 8);

      // Random traffic with random gaps.
      for (int i = 0; i < 10; i++) begin
         send(SAMPLE_W'($urandom));
         idle($urandom_range(0, 600));
      end

      // Reset in the middle of the right slot (fb = 45).
      k = 0;
      while (!(n > FRAME_CLKS && ((n - FIRST_LOAD) % FRAME_CLKS) == 45 * 2 * CLK_DIV)
             && k < 2000) begin
         tick(1'b0, '0);
         k++;
      end
      chk("fb45_align", 32'(k < 2000), 32'd1);
      chk("fb45_lrck",  32'(lrck),     32'd1);
      do_reset();
      idle(2 * FRAME_CLKS + 20);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Consumes the 16-bit signed samples produced by the waveform generators (triangle, sine, square) and serializes them onto a standard I2S link for the board audio codec/DAC.
- Generates BCLK and LRCK internally from the system clock and accepts samples through a valid/ready handshake with a one-sample holding buffer.
- Each accepted mono sample is transmitted on both the left and right channels of one frame.
- Repeats the last sample and flags underrun when no new sample is available at a frame boundary.

Parameters:
- SAMPLE_W, 16, sample width in bits (two's complement, MSB first on the wire).
- SLOT_W, 32, BCLK periods per channel slot; must satisfy SLOT_W >= SAMPLE_W+1.
- CLK_DIV, 8, clk cycles per BCLK half-period (minimum 1). Frame rate = f_clk/(2*CLK_DIV*2*SLOT_W), i.e. 48.83 kHz at 50 MHz with defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  SAMPLE_W  signed sample from the generator.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  holding buffer empty; the sample is accepted when valid&&ready.
- bclk  out  1  I2S bit clock.
- lrck  out  1  I2S word select: 0 = left, 1 = right.
- sdata  out  1  I2S serial data.
- frame_start  out  1  one-clk pulse when a new frame word is loaded.
- underrun  out  1  one-clk pulse, coincident with frame_start, when the previous word was reused.

Behaviour:
Reset values:
- bclk=0, lrck=0, sdata=0, sample_ready=1, frame_start=0, underrun=0.
- hold_full=0, hold_reg=0, frame_word=0, div_cnt=0, fb (frame-bit counter)=2*SLOT_W-1.

Divider and bit clock:
- div_cnt counts 0..CLK_DIV-1. At terminal count it wraps to 0 and bclk toggles.
- A 0->1 toggle is a "rise"; a 1->0 toggle is a "fall".
- First rise occurs CLK_DIV cycles after reset release.

Frame counter:
- On each fall, fb increments modulo 2*SLOT_W.
- fb wrapping to 0 (including the first fall after reset) is a frame load:
  - frame_word <= hold_reg if hold_full, otherwise unchanged.
  - hold_full cleared.
  - frame_start=1 for that clk.
  - underrun=1 for that clk if hold_full was 0.
  - frame_start and underrun assert after the first fall; underrun=1 on that first frame is expected.

Outputs (all registered, updated in the same clk as the fall):
- lrck = (fb >= SLOT_W).
- With p = fb mod SLOT_W:
  - sdata = frame_word[SAMPLE_W-p] for 1 <= p <= SAMPLE_W.
  - sdata = 0 otherwise.
- This gives the I2S one-bit delay after each LRCK edge, with MSB first and zero padding.
- The same word is sent in both slots.
- Outputs never change on a rise, so the receiver samples on rising BCLK.

Handshake:
- sample_ready = ~hold_full.
- On valid&&ready: hold_reg <= sample_in and hold_full <= 1.
- Accept and frame load in the same clk: the load uses the pre-cycle hold_full. If the buffer was empty, the load underruns and the newly accepted sample stays held for the next frame.
- If hold_full=1 at the load, ready was 0, so no simultaneous accept is possible.
- While ready=0, sample_valid is ignored; the generator must hold its sample.

Latency:
- An accepted sample drives its MSB on sdata at the fall with fb=1 after the next frame load.

Reset mid-frame:
- All state returns to reset values immediately (asynchronous).
- The partial frame is abandoned; no glitch beyond a truncated BCLK high phase.

Decomposition:
- Package audio_pkg:
  - localparams AUDIO_SAMPLE_W=16 and I2S_SLOT_W=32.
  - typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t.
  - Shared with the wave generators.
- Sub-module i2s_clk_div: div_cnt, bclk register, and bclk_rise/bclk_fall strobes.
- The top level holds the holding buffer, fb counter, frame_word and output muxing.

Test Plan (CLK_DIV=2, SLOT_W=32; frame = 256 clks):
1. Reset, then hold rst=1 for 5 clks -> all outputs at reset values; release; first bclk rise at clk 2, first fall at clk 4 with frame_start=1, underrun=1, lrck=0, sdata=0.
2. Present 16'hA5C3 with valid before the first load -> ready drops the clk after accept; after the frame load, decoded left and right words both equal 0xA5C3; bits p=17..31 are 0; lrck high for exactly 32 BCLK periods.
3. Stream 16'h8000, 16'h7FFF, 16'h0001, each presented as soon as ready -> three consecutive frames decode to those values with no underrun pulse after the first frame.
4. Stop valid after 16'h1234 -> the next frames repeat 0x1234, with underrun=1 at each frame_start; resuming with 16'h4321 -> the frame after acceptance carries 0x4321 and underrun stays 0.
5. Assert valid in the exact clk of a frame load while the buffer is empty -> that frame underruns; the accepted sample appears in the following frame.
6. Assert rst mid-right-slot (fb=45) -> outputs return to reset values in the same clk; after release the frame sequence restarts as in scenario 1.
